// File: rtl/decoder_4by16_pending_if.sv
// ---------------------------------------------------------------------------
// decoder_4by16_pending_if
//
// Bundles the index handshake, the pending clear port and the decoded /
// pending status outputs of decoder_4by16_pending.
//
// Handshake (valid/ready): an index transfers on a rising clk edge where
// in_valid and in_ready are both 1. in_ready is derived from registered
// state only, so it never depends on in_valid or data_in. While in_valid is
// high and in_ready is low, the producer must hold data_in stable until
// the transfer happens.
//
// Signals:
//   in_valid     producer -> block   data_in carries an index
//   in_ready     block -> producer   block can accept an index
//   data_in      producer -> block   encoded index, 0..OUT_W-1
//   clr_en       consumer -> block   apply clr_mask this cycle
//   clr_mask     consumer -> block   pending bits to retire
//   onehot_out   block -> consumer   registered one-hot decode
//   onehot_valid block -> consumer   one-cycle pulse qualifying onehot_out
//   pending      block -> consumer   registered pending bitmap
//   pending_any  block -> consumer   OR of pending
//   pending_cnt  block -> consumer   popcount of pending, 0..OUT_W
//   dup          block -> consumer   accepted index was already pending
//
// Modports: master = producer/consumer side, slave = decoder side.
// ---------------------------------------------------------------------------
interface decoder_4by16_pending_if #(
    parameter int IN_W = 4
);
    localparam int OUT_W = 2 ** IN_W;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  data_in;
    logic             clr_en;
    logic [OUT_W-1:0] clr_mask;
    logic [OUT_W-1:0] onehot_out;
    logic             onehot_valid;
    logic [OUT_W-1:0] pending;
    logic             pending_any;
    logic [IN_W:0]    pending_cnt;
    logic             dup;

    modport master (
        output in_valid,
        output data_in,
        output clr_en,
        output clr_mask,
        input  in_ready,
        input  onehot_out,
        input  onehot_valid,
        input  pending,
        input  pending_any,
        input  pending_cnt,
        input  dup
    );

    modport slave (
        input  in_valid,
        input  data_in,
        input  clr_en,
        input  clr_mask,
        output in_ready,
        output onehot_out,
        output onehot_valid,
        output pending,
        output pending_any,
        output pending_cnt,
        output dup
    );
endinterface

// File: rtl/decoder_4by16_pending.sv
// ---------------------------------------------------------------------------
// decoder_4by16_pending
//
// Decodes accepted IN_W-bit indices into a registered one-hot pulse and
// accumulates them into a pending bitmap that the downstream priority
// encoder uses as its request vector. The consumer retires serviced bits
// through clr_en/clr_mask.
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    decoder_4by16_pending_if.slave (handshake, clear, status)
//
// State: the pending register (with its registered popcount) and a
// single decode stage (onehot/valid/dup). There is no other sequencing.
// ---------------------------------------------------------------------------
module decoder_4by16_pending #(
    parameter int IN_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decoder_4by16_pending_if.slave bus
);
    localparam int OUT_W = 2 ** IN_W;

    // Registered state
    logic [OUT_W-1:0] pending_q;
    logic [IN_W:0]    pending_cnt_q;
    logic [OUT_W-1:0] onehot_q;
    logic             onehot_valid_q;
    logic             dup_q;

    // Next-state terms
    logic             accept;
    logic [OUT_W-1:0] set_vec;
    logic [OUT_W-1:0] clr_vec;
    logic [OUT_W-1:0] pending_next;
    logic [IN_W:0]    pending_cnt_next;
    logic             dup_next;

    // Popcount sized IN_W+1 bits so a full bitmap (OUT_W) fits without wrap.
    function automatic logic [IN_W:0] popcount(input logic [OUT_W-1:0] v);
        logic [IN_W:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + {{IN_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Ready only while at least one pending bit is free; from registers only.
    assign bus.in_ready = ~(&pending_q);
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (accept) begin
            set_vec[bus.data_in] = 1'b1;
        end
        if (bus.clr_en) begin
            clr_vec = bus.clr_mask;
        end
    end

    // Clear is applied before set, so a same-cycle set/clear of one bit
    // leaves it set.
    assign pending_next     = (pending_q & ~clr_vec) | set_vec;
    assign pending_cnt_next = popcount(pending_next);

    // A duplicate is only reported when the bit stays pending through this
    // edge; if the consumer clears it in the same cycle the new accept is
    // a fresh request rather than a repeat.
    assign dup_next = accept & pending_q[bus.data_in] & ~clr_vec[bus.data_in];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q      <= '0;
            pending_cnt_q  <= '0;
            onehot_q       <= '0;
            onehot_valid_q <= 1'b0;
            dup_q          <= 1'b0;
        end else begin
            pending_q      <= pending_next;
            pending_cnt_q  <= pending_cnt_next;
            // set_vec is zero without an accept, so onehot_out idles at 0.
            onehot_q       <= set_vec;
            onehot_valid_q <= accept;
            dup_q          <= dup_next;
        end
    end

    assign bus.onehot_out   = onehot_q;
    assign bus.onehot_valid = onehot_valid_q;
    assign bus.pending      = pending_q;
    assign bus.pending_any  = |pending_q;
    assign bus.pending_cnt  = pending_cnt_q;
    assign bus.dup          = dup_q;

endmodule

// File: tb/tb_decoder_4by16_pending.sv
// ---------------------------------------------------------------------------
// tb_decoder_4by16_pending
//
// Directed stimulus for decoder_4by16_pending. Each expected decode pulse
// (onehot, dup, pending, pending_cnt) is pushed into exp_q when the index
// is issued; a monitor pops and compares whenever onehot_valid is high.
// Non-pulse state (reset values, in_ready, clears) is checked inline.
// ---------------------------------------------------------------------------
module tb_decoder_4by16_pending;
    localparam int IN_W  = 4;
    localparam int OUT_W = 16;
    localparam int EXP_W = OUT_W + 1 + OUT_W + IN_W + 1;

    logic clk;
    logic rst_n;

    decoder_4by16_pending_if #(.IN_W(IN_W)) bus ();

    decoder_4by16_pending #(.IN_W(IN_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // {onehot, dup, pending, pending_cnt}
    logic [EXP_W-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, actual=running required=done");
        $fatal(1);
    end

    // ---------------- compare helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [IN_W-1:0] idx,
                         input logic ce, input logic [OUT_W-1:0] m);
        @(negedge clk);
        bus.in_valid = v;
        bus.data_in  = idx;
        bus.clr_en   = ce;
        bus.clr_mask = m;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, '0, 1'b0, '0);
        end
    endtask

    task automatic expect_pulse(input logic [OUT_W-1:0] oh, input logic d,
                                input logic [OUT_W-1:0] p, input logic [IN_W:0] c);
        exp_q.push_back({oh, d, p, c});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] e;
        if (rst_n) begin
            if (bus.onehot_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: actual onehot=%0h required=no pulse", bus.onehot_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("onehot_out",  32'(bus.onehot_out),  32'(e[EXP_W-1 -: OUT_W]));
                    chk("dup",         32'(bus.dup),         32'(e[OUT_W+IN_W+1]));
                    chk("pending",     32'(bus.pending),     32'(e[IN_W+1 +: OUT_W]));
                    chk("pending_cnt", 32'(bus.pending_cnt), 32'(e[IN_W:0]));
                end
            end else begin
                chk("idle_onehot", 32'(bus.onehot_out), 32'h0);
                chk("idle_dup",    32'(bus.dup),        32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [OUT_W-1:0] exp_pend;

        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.clr_en   = 1'b0;
        bus.clr_mask = '0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_onehot",       32'(bus.onehot_out),   32'h0);
        chk("rst_onehot_valid", 32'(bus.onehot_valid), 32'h0);
        chk("rst_pending",      32'(bus.pending),      32'h0);
        chk("rst_cnt",          32'(bus.pending_cnt),  32'h0);
        chk("rst_dup",          32'(bus.dup),          32'h0);
        chk("rst_any",          32'(bus.pending_any),  32'h0);
        chk("rst_ready",        32'(bus.in_ready),     32'h1);

        // Single accept of index 5
        expect_pulse(16'h0020, 1'b0, 16'h0020, 5'd1);
        drive(1'b1, 4'd5, 1'b0, '0);
        idle(1);
        chk("any_after_5", 32'(bus.pending_any), 32'h1);
        idle(1);
        chk("valid_drops", 32'(bus.onehot_valid), 32'h0);

        // Duplicate of 5
        expect_pulse(16'h0020, 1'b1, 16'h0020, 5'd1);
        drive(1'b1, 4'd5, 1'b0, '0);
        idle(1);

        // Accept 5 while clearing 5: set wins, no dup
        expect_pulse(16'h0020, 1'b0, 16'h0020, 5'd1);
        drive(1'b1, 4'd5, 1'b1, 16'h0020);
        idle(1);

        // Accept 3 while clearing 0 and 5
        expect_pulse(16'h0008, 1'b0, 16'h0008, 5'd1);
        drive(1'b1, 4'd3, 1'b1, 16'h0021);
        idle(1);

        // Clear everything, then clear already-zero bits
        drive(1'b0, '0, 1'b1, 16'hFFFF);
        idle(1);
        chk("clr_all_pending", 32'(bus.pending),     32'h0);
        chk("clr_all_cnt",     32'(bus.pending_cnt), 32'h0);
        chk("clr_all_any",     32'(bus.pending_any), 32'h0);
        drive(1'b0, '0, 1'b1, 16'h0F0F);
        idle(1);
        chk("clr_zero_pending", 32'(bus.pending), 32'h0);

        // Fill 0..15 back-to-back
        for (int i = 0; i < OUT_W; i++) begin
            exp_pend = 16'((17'h1 << (i + 1)) - 17'h1);
            expect_pulse(16'h1 << i, 1'b0, exp_pend, 5'(i + 1));
            drive(1'b1, 4'(i), 1'b0, '0);
        end

        // Full: further requests ignored
        drive(1'b1, 4'd7, 1'b0, '0);
        chk("full_ready", 32'(bus.in_ready), 32'h0);
        idle(1);
        chk("full_pending", 32'(bus.pending),     32'hFFFF);
        chk("full_cnt",     32'(bus.pending_cnt), 32'd16);

        // Clear 15 and 0 from full
        drive(1'b0, '0, 1'b1, 16'h8001);
        chk("full_ready_hold", 32'(bus.in_ready), 32'h0);
        idle(1);
        chk("unfull_pending", 32'(bus.pending),     32'h7FFE);
        chk("unfull_cnt",     32'(bus.pending_cnt), 32'd14);
        chk("unfull_ready",   32'(bus.in_ready),    32'h1);

        // Accept 9, then reset before the next edge: no pulse
        drive(1'b1, 4'd9, 1'b0, '0);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_valid",   32'(bus.onehot_valid), 32'h0);
        chk("midrst_onehot",  32'(bus.onehot_out),   32'h0);
        chk("midrst_pending", 32'(bus.pending),      32'h0);
        chk("midrst_cnt",     32'(bus.pending_cnt),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("postrst_ready",   32'(bus.in_ready), 32'h1);
        chk("postrst_pending", 32'(bus.pending),  32'h0);
        idle(2);

        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
